// File: rtl/sdram_wb_bridge.sv
// Wishbone B4 classic slave in front of the SDRAM controller user port.
// Keeps a small sequential prefetch buffer and merges byte-lane writes.
module sdram_wb_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h3800_0000,
    parameter logic [31:0] ADDR_MASK = 32'h01FF_FFFF,
    parameter int unsigned PF_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [22:0] ctl_addr,
    output logic        ctl_rw,
    output logic [31:0] ctl_wdata,
    input  logic [31:0] ctl_rdata,
    input  logic        ctl_busy,
    output logic        ctl_in_valid,
    input  logic        ctl_out_valid
);

    localparam int unsigned IdxW = $clog2(PF_DEPTH);
    localparam int unsigned CntW = IdxW + 1;

    typedef enum logic [3:0] {
        StIdle, StRdIssue, StRdWait, StWrIssue, StRmwIssue,
        StRmwWait, StPfIssue, StPfWait, StAck
    } state_e;

    state_e                state_q, state_d;
    logic [22:0]           tag_q, tag_d;
    logic [31:0]           buf_q [PF_DEPTH];
    logic [31:0]           buf_d [PF_DEPTH];
    logic [PF_DEPTH-1:0]   vld_q, vld_d;
    logic [CntW-1:0]       pf_cnt_q, pf_cnt_d;
    logic [22:0]           wr_addr_q, wr_addr_d;
    logic [31:0]           wr_data_q, wr_data_d;
    logic                  wr_sent_q, wr_sent_d;
    logic                  ack_q, ack_d;
    logic [31:0]           dat_q, dat_d;
    logic                  civ_q, civ_d;
    logic [22:0]           caddr_q, caddr_d;
    logic                  crw_q, crw_d;
    logic [31:0]           cwdata_q, cwdata_d;

    logic [22:0]     wa, off;
    logic [IdxW-1:0] slot;
    logic            hit_win, req, take_req, buf_hit, can_issue, cyc_stb;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = sel[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return res;
    endfunction

    assign wa        = wbs_adr_i[24:2];
    assign off       = wa - tag_q;
    assign slot      = off[IdxW-1:0];
    assign hit_win   = ((wbs_adr_i & ~ADDR_MASK) == BASE_ADDR);
    assign cyc_stb   = wbs_cyc_i & wbs_stb_i;
    // The ack cycle never samples a new request, so the held strobe is not re-decoded.
    assign req       = cyc_stb & hit_win & ~ack_q;
    assign take_req  = req & ((state_q == StIdle) | (state_q == StPfIssue));
    assign buf_hit   = (off < 23'(PF_DEPTH)) & vld_q[slot];
    // Controller busy lags one cycle, so never issue right after a pulse.
    assign can_issue = ~ctl_busy & ~civ_q;

    always_comb begin
        state_d   = state_q;
        tag_d     = tag_q;
        buf_d     = buf_q;
        vld_d     = vld_q;
        pf_cnt_d  = pf_cnt_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_sent_d = wr_sent_q;
        ack_d     = 1'b0;
        dat_d     = dat_q;
        civ_d     = 1'b0;
        caddr_d   = caddr_q;
        crw_d     = crw_q;
        cwdata_d  = cwdata_q;

        if (take_req) begin
            if (!wbs_we_i) begin
                if (buf_hit) begin
                    ack_d   = 1'b1;
                    dat_d   = buf_q[slot];
                    state_d = StAck;
                end else begin
                    vld_d   = '0;
                    tag_d   = wa;
                    state_d = StRdIssue;
                end
            end else if (wbs_sel_i == 4'h0) begin
                ack_d   = 1'b1;
                state_d = StAck;
            end else begin
                wr_addr_d = wa;
                if (wbs_sel_i == 4'hF || buf_hit) begin
                    wr_data_d = merge_bytes(buf_q[slot], wbs_dat_i, wbs_sel_i);
                    if (buf_hit) buf_d[slot] = wr_data_d;
                    state_d = StWrIssue;
                end else begin
                    state_d = StRmwIssue;
                end
            end
        end else begin
            unique case (state_q)
                StIdle: ;
                StRdIssue: if (can_issue) begin
                    civ_d   = 1'b1;
                    caddr_d = tag_q;
                    crw_d   = 1'b0;
                    state_d = StRdWait;
                end
                StRdWait: if (ctl_out_valid) begin
                    buf_d[0] = ctl_rdata;
                    vld_d[0] = 1'b1;
                    if (cyc_stb) begin
                        ack_d = 1'b1;
                        dat_d = ctl_rdata;
                    end
                    pf_cnt_d = CntW'(1);
                    state_d  = StPfIssue;
                end
                StPfIssue: begin
                    if (pf_cnt_q == CntW'(PF_DEPTH)) begin
                        state_d = StIdle;
                    end else if (can_issue) begin
                        civ_d   = 1'b1;
                        caddr_d = tag_q + 23'(pf_cnt_q);
                        crw_d   = 1'b0;
                        state_d = StPfWait;
                    end
                end
                StPfWait: if (ctl_out_valid) begin
                    buf_d[pf_cnt_q[IdxW-1:0]] = ctl_rdata;
                    vld_d[pf_cnt_q[IdxW-1:0]] = 1'b1;
                    pf_cnt_d = pf_cnt_q + CntW'(1);
                    state_d  = StPfIssue;
                end
                StRmwIssue: if (can_issue) begin
                    civ_d   = 1'b1;
                    caddr_d = wr_addr_q;
                    crw_d   = 1'b0;
                    state_d = StRmwWait;
                end
                StRmwWait: if (ctl_out_valid) begin
                    if (cyc_stb) begin
                        wr_data_d = merge_bytes(ctl_rdata, wbs_dat_i, wbs_sel_i);
                        state_d   = StWrIssue;
                    end else begin
                        state_d = StIdle;
                    end
                end
                StWrIssue: begin
                    if (wr_sent_q) begin
                        wr_sent_d = 1'b0;
                        ack_d     = cyc_stb;
                        state_d   = StAck;
                    end else if (can_issue) begin
                        civ_d     = 1'b1;
                        caddr_d   = wr_addr_q;
                        crw_d     = 1'b1;
                        cwdata_d  = wr_data_q;
                        wr_sent_d = 1'b1;
                    end
                end
                StAck:   state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            tag_q     <= '0;
            vld_q     <= '0;
            pf_cnt_q  <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_sent_q <= 1'b0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            civ_q     <= 1'b0;
            caddr_q   <= '0;
            crw_q     <= 1'b0;
            cwdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            tag_q     <= tag_d;
            vld_q     <= vld_d;
            pf_cnt_q  <= pf_cnt_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_sent_q <= wr_sent_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            civ_q     <= civ_d;
            caddr_q   <= caddr_d;
            crw_q     <= crw_d;
            cwdata_q  <= cwdata_d;
        end
    end

    // Buffer data is qualified by vld_q, so it needs no reset.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = dat_q;
    assign ctl_in_valid = civ_q;
    assign ctl_addr     = caddr_q;
    assign ctl_rw       = crw_q;
    assign ctl_wdata    = cwdata_q;

endmodule

// File: tb/tb_sdram_wb_bridge.sv
// Scoreboard bench for sdram_wb_bridge with a small SDRAM controller model.
module tb_sdram_wb_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [22:0] ctl_addr;
    logic        ctl_rw;
    logic [31:0] ctl_wdata;
    logic [31:0] ctl_rdata = '0;
    logic        ctl_busy = 1'b0;
    logic        ctl_in_valid;
    logic        ctl_out_valid = 1'b0;

    always #5 clk = ~clk;

    sdram_wb_bridge dut (
        .clk          (clk),
        .rst          (rst),
        .wbs_cyc_i    (wbs_cyc_i),
        .wbs_stb_i    (wbs_stb_i),
        .wbs_we_i     (wbs_we_i),
        .wbs_sel_i    (wbs_sel_i),
        .wbs_adr_i    (wbs_adr_i),
        .wbs_dat_i    (wbs_dat_i),
        .wbs_ack_o    (wbs_ack_o),
        .wbs_dat_o    (wbs_dat_o),
        .ctl_addr     (ctl_addr),
        .ctl_rw       (ctl_rw),
        .ctl_wdata    (ctl_wdata),
        .ctl_rdata    (ctl_rdata),
        .ctl_busy     (ctl_busy),
        .ctl_in_valid (ctl_in_valid),
        .ctl_out_valid(ctl_out_valid)
    );

    int checks = 0;
    int failures = 0;

    // kind: 1 = ack one cycle after out_valid, 2 = one cycle after request,
    // 3 = one cycle after the ctl_in_valid pulse
    typedef struct { logic [31:0] dat; bit chk; int kind; } wb_exp_t;
    typedef struct { logic rw; logic [22:0] addr; logic [31:0] wdata; } ctl_exp_t;
    typedef struct { int due; logic [22:0] a; } pend_t;
    wb_exp_t  wb_q[$];
    ctl_exp_t ctl_q[$];

    // Controller model: reads return after 3 cycles, writes update memory.
    logic [31:0] mem [int];
    pend_t       pend[$];
    int          mcyc = 0;

    function automatic logic [31:0] mem_rd(input logic [22:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return 32'hD000_0000 | {9'd0, a};
    endfunction

    initial begin
        mem[4]    = 32'hA5A5_0001;
        mem[32'h40] = 32'h1111_1111;
        forever begin
            @(posedge clk);
            #1;
            mcyc++;
            ctl_out_valid = 1'b0;
            if (pend.size() > 0 && pend[0].due <= mcyc) begin
                ctl_out_valid = 1'b1;
                ctl_rdata     = mem_rd(pend[0].a);
                void'(pend.pop_front());
            end
            if (ctl_in_valid) begin
                if (ctl_rw) begin
                    mem[int'(ctl_addr)] = ctl_wdata;
                end else begin
                    pend_t p;
                    p.due = mcyc + 3;
                    p.a   = ctl_addr;
                    pend.push_back(p);
                end
            end
        end
    end

    // Monitor
    int   cycle = 0, last_ov = -100, last_iv = -100, req_cyc = -100;
    int   iv_count = 0, ack_count = 0, consec_ack = 0;
    logic prev_req = 1'b0, prev_busy = 1'b0, prev_iv = 1'b0, prev_ack = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            cycle++;
            if (!rst) begin
                if (wbs_cyc_i && wbs_stb_i && !prev_req) req_cyc = cycle;
                if (ctl_out_valid) last_ov = cycle;
                if (ctl_in_valid) begin
                    iv_count++;
                    last_iv = cycle;
                    checks++;
                    if (prev_busy || prev_iv) begin
                        failures++;
                        $display("FAIL issue_rule: pulse with prev busy=%0d prev pulse=%0d, required 0/0",
                                 prev_busy, prev_iv);
                    end
                    checks++;
                    if (ctl_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_ctl: rw=%0d addr=%h, required no request",
                                 ctl_rw, ctl_addr);
                    end else begin
                        ctl_exp_t e;
                        e = ctl_q.pop_front();
                        if (ctl_rw !== e.rw || ctl_addr !== e.addr ||
                            (e.rw && ctl_wdata !== e.wdata)) begin
                            failures++;
                            $display("FAIL ctl_req: got rw=%0d addr=%h wdata=%h, required rw=%0d addr=%h wdata=%h",
                                     ctl_rw, ctl_addr, ctl_wdata, e.rw, e.addr, e.wdata);
                        end
                    end
                end
                if (wbs_ack_o) begin
                    ack_count++;
                    if (prev_ack) consec_ack++;
                    checks++;
                    if (wb_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_ack: dat=%h, required no ack", wbs_dat_o);
                    end else begin
                        wb_exp_t e;
                        int      ref_c;
                        e = wb_q.pop_front();
                        case (e.kind)
                            1:       ref_c = last_ov + 1;
                            2:       ref_c = req_cyc + 1;
                            default: ref_c = last_iv + 1;
                        endcase
                        if (cycle != ref_c || (e.chk && wbs_dat_o !== e.dat)) begin
                            failures++;
                            $display("FAIL wb_ack: cycle %0d dat %h, required cycle %0d dat %h",
                                     cycle, wbs_dat_o, ref_c, e.dat);
                        end
                    end
                end
            end
            prev_req  = wbs_cyc_i & wbs_stb_i;
            prev_busy = ctl_busy;
            prev_iv   = ctl_in_valid;
            prev_ack  = wbs_ack_o;
        end
    end

    task automatic exp_wb(input logic [31:0] dat, input bit chk, input int kind);
        wb_exp_t e;
        e.dat = dat; e.chk = chk; e.kind = kind;
        wb_q.push_back(e);
    endtask

    task automatic exp_ctl(input logic rw, input logic [22:0] addr, input logic [31:0] wdata);
        ctl_exp_t e;
        e.rw = rw; e.addr = addr; e.wdata = wdata;
        ctl_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic check_reset();
        chk("rst_ack", 32'(wbs_ack_o), 32'd0);
        chk("rst_dat", wbs_dat_o, 32'd0);
        chk("rst_in_valid", 32'(ctl_in_valid), 32'd0);
        chk("rst_rw", 32'(ctl_rw), 32'd0);
        chk("rst_addr", 32'(ctl_addr), 32'd0);
        chk("rst_wdata", ctl_wdata, 32'd0);
    endtask

    task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                           input logic [31:0] dat, input int budget, input string name);
        bit got = 1'b0;
        @(posedge clk);
        #1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_sel_i = sel;  wbs_adr_i = adr;  wbs_dat_i = dat;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (wbs_ack_o) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s: no ack within %0d cycles, required ack", name, budget);
        end
        @(posedge clk);
        #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base_iv, base_ack;
        bit got;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #1 rst = 1'b0;

        // Read miss with prefetch of the following three words
        for (int i = 4; i < 8; i++) exp_ctl(1'b0, 23'(i), 32'h0);
        exp_wb(32'hA5A5_0001, 1'b1, 1);
        wb_xfer(32'h3800_0010, 1'b0, 4'hF, 32'h0, 30, "rd_miss");
        idle(30);

        exp_wb(32'hD000_0005, 1'b1, 2);
        wb_xfer(32'h3800_0014, 1'b0, 4'hF, 32'h0, 10, "rd_hit");

        exp_ctl(1'b1, 23'h0, 32'h1234_5678);
        exp_wb(32'h0, 1'b0, 3);
        wb_xfer(32'h3800_0000, 1'b1, 4'hF, 32'h1234_5678, 20, "wr_full");

        // Partial write over a buffered word: merged without a read
        exp_ctl(1'b1, 23'h6, 32'hD000_00EE);
        exp_wb(32'h0, 1'b0, 3);
        wb_xfer(32'h3800_0018, 1'b1, 4'b0001, 32'h0000_00EE, 20, "wr_buf_partial");

        exp_wb(32'hD000_00EE, 1'b1, 2);
        wb_xfer(32'h3800_0018, 1'b0, 4'hF, 32'h0, 10, "rd_after_wr");

        exp_wb(32'h0, 1'b0, 2);
        wb_xfer(32'h3800_0020, 1'b1, 4'h0, 32'hFFFF_FFFF, 10, "wr_sel0");

        exp_ctl(1'b0, 23'h40, 32'h0);
        exp_ctl(1'b1, 23'h40, 32'h1111_AB11);
        exp_wb(32'h0, 1'b0, 3);
        wb_xfer(32'h3800_0100, 1'b1, 4'b0010, 32'h0000_AB00, 40, "wr_rmw");

        // Out-of-window request is ignored
        base_iv  = iv_count;
        base_ack = ack_count;
        @(posedge clk);
        #1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3000_0010;
        idle(6);
        #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(negedge clk);
        chk("nohit_ctl", 32'(iv_count), 32'(base_iv));
        chk("nohit_ack", 32'(ack_count), 32'(base_ack));

        // Miss while the controller is busy
        @(posedge clk);
        #1 ctl_busy = 1'b1;
        for (int i = 0; i < 4; i++) exp_ctl(1'b0, 23'h80 + 23'(i), 32'h0);
        exp_wb(32'hD000_0080, 1'b1, 1);
        base_iv = iv_count;
        fork
            wb_xfer(32'h3800_0200, 1'b0, 4'hF, 32'h0, 60, "rd_busy");
            begin
                idle(10);
                @(negedge clk);
                chk("busy_no_issue", 32'(iv_count), 32'(base_iv));
                @(posedge clk);
                #1 ctl_busy = 1'b0;
            end
        join
        idle(30);

        // Prefetch wraps at the top of the word space
        exp_ctl(1'b0, 23'h7F_FFFF, 32'h0);
        for (int i = 0; i < 3; i++) exp_ctl(1'b0, 23'(i), 32'h0);
        exp_wb(32'hD07F_FFFF, 1'b1, 1);
        wb_xfer(32'h39FF_FFFC, 1'b0, 4'hF, 32'h0, 30, "rd_wrap");
        idle(30);

        // Drop cyc during the miss, then reset during the prefetch
        exp_ctl(1'b0, 23'h200, 32'h0);
        exp_ctl(1'b0, 23'h201, 32'h0);
        base_iv = iv_count;
        @(posedge clk);
        #1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3800_0800;
        idle(3);
        #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (iv_count >= base_iv + 2) begin
                got = 1'b1;
                break;
            end
        end
        chk("prefetch_started", 32'(got), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        idle(2);
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        idle(12);

        // Valids were cleared, so the old slot-0 word must miss again
        for (int i = 0; i < 4; i++) exp_ctl(1'b0, 23'h200 + 23'(i), 32'h0);
        exp_wb(32'hD000_0200, 1'b1, 1);
        wb_xfer(32'h3800_0800, 1'b0, 4'hF, 32'h0, 30, "rd_after_rst");
        idle(30);

        chk("wb_queue_empty", 32'(wb_q.size()), 32'd0);
        chk("ctl_queue_empty", 32'(ctl_q.size()), 32'd0);
        chk("consec_ack", 32'(consec_ack), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
